// File: rtl/div_sequencer_if.sv
// Execute-stage divide handshake bundle between the pipeline and div_sequencer.
// Latency: none (wires only).
// Backpressure: divider stalls the pipeline via E_div_stall; pipeline releases results via E_ena.
//
// Signals:
//   E_div_valid / E_div_signed / E_rs_value / E_rt_value : issued divide and its operands
//   E_ena / M_except                                      : E->M advance and M-stage flush
//   E_div_stall / E_div_hi / E_div_lo / E_div_ready       : stall request and HI/LO results
// master = pipeline side, slave = divider side.
interface div_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             E_div_valid;
    logic             E_div_signed;
    logic [WIDTH-1:0] E_rs_value;
    logic [WIDTH-1:0] E_rt_value;
    logic             E_ena;
    logic             M_except;
    logic             E_div_stall;
    logic [WIDTH-1:0] E_div_hi;
    logic [WIDTH-1:0] E_div_lo;
    logic             E_div_ready;

    modport master (
        output E_div_valid, E_div_signed, E_rs_value, E_rt_value, E_ena, M_except,
        input  E_div_stall, E_div_hi, E_div_lo, E_div_ready
    );

    modport slave (
        input  E_div_valid, E_div_signed, E_rs_value, E_rt_value, E_ena, M_except,
        output E_div_stall, E_div_hi, E_div_lo, E_div_ready
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring DIV/DIVU controller for the master E slot.
// Latency: 33-cycle stall (1 issue + 32 iterations), result ready on the following cycle.
// Backpressure: holds HI/LO in DONE until E_ena; M_except aborts and drops stall the same cycle.
//
// Ports: clk, resetn (synchronous, active-low), bus (div_sequencer_if.slave).
// Optional build macro DIV_EARLY_OUT_EN: when |rt| > |rs| the divide completes from IDLE
// directly (1-cycle stall, LO=0, HI=rs); results are identical with or without it.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    div_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes; for DIVU the raw bits are used unchanged.
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic             start;
    logic             early_out;

    assign rs_neg = bus.E_div_signed & bus.E_rs_value[WIDTH-1];
    assign rt_neg = bus.E_div_signed & bus.E_rt_value[WIDTH-1];
    assign abs_rs = rs_neg ? negate(bus.E_rs_value) : bus.E_rs_value;
    assign abs_rt = rt_neg ? negate(bus.E_rt_value) : bus.E_rt_value;
    assign start  = (state == IDLE) & bus.E_div_valid & ~bus.M_except;

`ifdef DIV_EARLY_OUT_EN
    // Divisor magnitude larger than dividend: quotient is 0, remainder is the dividend.
    assign early_out = (abs_rt > abs_rs);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits; if its top
    // bit (rem_q MSB) is set it certainly exceeds the divisor, and the low WIDTH bits of
    // the trial difference are then exact.
    logic [WIDTH:0]   shift_hi;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             last_iter;

    assign shift_hi  = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shift_hi - {1'b0, divisor_q};
    assign take      = rem_q[WIDTH-1] | ~trial[WIDTH];
    assign rem_nxt   = take ? trial[WIDTH-1:0] : shift_hi[WIDTH-1:0];
    assign quo_nxt   = {quo_q[WIDTH-2:0], take};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)      state_nxt = early_out ? DONE : BUSY;
            BUSY: if (last_iter)  state_nxt = DONE;
            DONE: if (bus.E_ena)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
        // Flush wins in every state; any partial result is abandoned.
        if (bus.M_except) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else if (start) begin
            divisor_q <= abs_rt;
            quo_q     <= abs_rs;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= rs_neg ^ rt_neg;
            r_neg_q   <= rs_neg;
            if (early_out) begin
                // Sign-corrected |rs| is rs itself.
                lo_q <= '0;
                hi_q <= bus.E_rs_value;
            end
        end else if ((state == BUSY) && !bus.M_except) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            // Sign-correct on the way into DONE so HI/LO are plain registers there.
            if (last_iter) begin
                lo_q <= q_neg_q ? negate(quo_nxt) : quo_nxt;
                hi_q <= r_neg_q ? negate(rem_nxt) : rem_nxt;
            end
        end
    end

    // Combinational so the stall covers the issue cycle; dropped under flush or reset.
    assign bus.E_div_stall = resetn & bus.E_div_valid & ~bus.M_except &
                             ((state == IDLE) | (state == BUSY));
    assign bus.E_div_ready = (state == DONE);
    assign bus.E_div_hi    = hi_q;
    assign bus.E_div_lo    = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
    logic clk;
    logic resetn;

    int n_cmp;
    int n_bad;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_CYC = 1;
`else
    localparam int EO_CYC = 33;
`endif

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one divide and records what the DUT does. Returns the number of stall cycles,
    // HI/LO/ready at the first non-stall cycle, the number of bad cycles while holding in
    // DONE with E_ena low, and ready/stall the cycle after E_ena is raised.
    task automatic do_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                          input int hold,
                          output int n, output logic [31:0] lo, output logic [31:0] hi,
                          output logic rdy, output int hold_bad,
                          output logic rdy_after, output logic stall_after);
        n = 0;
        hold_bad = 0;
        @(posedge clk);
        #1;
        bus.E_div_valid  = 1'b1;
        bus.E_div_signed = sgn;
        bus.E_rs_value   = rs;
        bus.E_rt_value   = rt;
        bus.E_ena        = 1'b0;
        bus.M_except     = 1'b0;
        #1;
        while (bus.E_div_stall && n < 100) begin
            n++;
            @(posedge clk);
            #2;
        end
        lo  = bus.E_div_lo;
        hi  = bus.E_div_hi;
        rdy = bus.E_div_ready;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #2;
            if (bus.E_div_stall !== 1'b0 || bus.E_div_ready !== 1'b1 ||
                bus.E_div_lo !== lo || bus.E_div_hi !== hi)
                hold_bad++;
        end
        bus.E_ena = 1'b1;
        @(posedge clk);
        #1;
        bus.E_div_valid = 1'b0;
        bus.E_ena       = 1'b0;
        #1;
        rdy_after   = bus.E_div_ready;
        stall_after = bus.E_div_stall;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.E_div_valid  = 1'b0;
        bus.E_div_signed = 1'b0;
        bus.E_rs_value   = '0;
        bus.E_rt_value   = '0;
        bus.E_ena        = 1'b0;
        bus.M_except     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.E_div_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.E_div_stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall got %0b want 0", bus.E_div_stall);
        end
        n_cmp++;
        if (bus.E_div_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready got %0b want 0", bus.E_div_ready);
        end
        n_cmp++;
        if (bus.E_div_hi !== 32'h0) begin
            n_bad++; $display("FAIL reset_hi got %h want 0", bus.E_div_hi);
        end
        n_cmp++;
        if (bus.E_div_lo !== 32'h0) begin
            n_bad++; $display("FAIL reset_lo got %h want 0", bus.E_div_lo);
        end
        bus.E_div_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_divu_basic();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        do_div(1'b0, 32'd100, 32'd7, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL divu_stall_cycles got %0d want 33", n); end
        n_cmp++;
        if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", lo); end
        n_cmp++;
        if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", hi); end
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL divu_ready got %0b want 1", rdy); end
        n_cmp++;
        if (ra !== 1'b0) begin n_bad++; $display("FAIL divu_ready_after got %0b want 0", ra); end
        n_cmp++;
        if (sa !== 1'b0) begin n_bad++; $display("FAIL divu_stall_after got %0b want 0", sa); end
    endtask

    task automatic test_signed();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_m7_2_lo got %h want fffffffd", lo); end
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_m7_2_hi got %h want ffffffff", hi); end
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_min_m1_lo got %h want 80000000", lo); end
        n_cmp++;
        if (hi !== 32'h0) begin n_bad++; $display("FAIL div_min_m1_hi got %h want 00000000", hi); end
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL div_min_m1_cycles got %0d want 33", n); end
    endtask

    task automatic test_div_by_zero();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        do_div(1'b0, 32'd7, 32'd0, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL divz_cycles got %0d want 33", n); end
        n_cmp++;
        if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_lo got %h want ffffffff", lo); end
        n_cmp++;
        if (hi !== 32'd7) begin n_bad++; $display("FAIL divz_hi got %h want 00000007", hi); end
    endtask

    task automatic test_hold();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        do_div(1'b1, 32'd20, 32'd3, 5, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (lo !== 32'd6) begin n_bad++; $display("FAIL hold_lo got %h want 00000006", lo); end
        n_cmp++;
        if (hi !== 32'd2) begin n_bad++; $display("FAIL hold_hi got %h want 00000002", hi); end
        n_cmp++;
        if (hb !== 0) begin n_bad++; $display("FAIL hold_stable got %0d bad cycles want 0", hb); end
        n_cmp++;
        if (ra !== 1'b0) begin n_bad++; $display("FAIL hold_release_ready got %0b want 0", ra); end
    endtask

    task automatic test_flush();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        @(posedge clk);
        #1;
        bus.E_div_valid  = 1'b1;
        bus.E_div_signed = 1'b0;
        bus.E_rs_value   = 32'd1000;
        bus.E_rt_value   = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        bus.M_except = 1'b1;
        #1;
        n_cmp++;
        if (bus.E_div_stall !== 1'b0) begin
            n_bad++; $display("FAIL flush_stall got %0b want 0", bus.E_div_stall);
        end
        @(posedge clk);
        #1;
        bus.M_except    = 1'b0;
        bus.E_div_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.E_div_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_ready got %0b want 0", bus.E_div_ready);
        end
        do_div(1'b0, 32'd9, 32'd3, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL post_flush_cycles got %0d want 33", n); end
        n_cmp++;
        if (lo !== 32'd3) begin n_bad++; $display("FAIL post_flush_lo got %h want 00000003", lo); end
        n_cmp++;
        if (hi !== 32'd0) begin n_bad++; $display("FAIL post_flush_hi got %h want 00000000", hi); end
    endtask

    task automatic test_early_out();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        do_div(1'b0, 32'd5, 32'd9, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (n !== EO_CYC) begin n_bad++; $display("FAIL eo_cycles got %0d want %0d", n, EO_CYC); end
        n_cmp++;
        if (lo !== 32'd0) begin n_bad++; $display("FAIL eo_lo got %h want 00000000", lo); end
        n_cmp++;
        if (hi !== 32'd5) begin n_bad++; $display("FAIL eo_hi got %h want 00000005", hi); end
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL eo_ready got %0b want 1", rdy); end
        do_div(1'b1, 32'hFFFF_FFFB, 32'd9, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (lo !== 32'd0) begin n_bad++; $display("FAIL eo_signed_lo got %h want 00000000", lo); end
        n_cmp++;
        if (hi !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL eo_signed_hi got %h want fffffffb", hi); end
    endtask

    task automatic test_reset_mid_busy();
        int n, hb; logic [31:0] lo, hi; logic rdy, ra, sa;
        @(posedge clk);
        #1;
        bus.E_div_valid  = 1'b1;
        bus.E_div_signed = 1'b0;
        bus.E_rs_value   = 32'd100;
        bus.E_rt_value   = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.E_div_stall !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy_stall got %0b want 0", bus.E_div_stall);
        end
        @(posedge clk);
        #1;
        bus.E_div_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.E_div_hi !== 32'h0) begin
            n_bad++; $display("FAIL rst_busy_hi got %h want 00000000", bus.E_div_hi);
        end
        n_cmp++;
        if (bus.E_div_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy_ready got %0b want 0", bus.E_div_ready);
        end
        resetn = 1'b1;
        do_div(1'b0, 32'd100, 32'd7, 0, n, lo, hi, rdy, hb, ra, sa);
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL rst_recover_cycles got %0d want 33", n); end
        n_cmp++;
        if (lo !== 32'd14) begin n_bad++; $display("FAIL rst_recover_lo got %h want 0000000e", lo); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_by_zero();
        test_hold();
        test_flush();
        test_early_out();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
